// File: rtl/bcd_pkg.sv
// Shared 7-segment glyph constants and the BCD-to-segment lookup used by the
// display scanner. All constants are active-high in the order {g,f,e,d,c,b,a}.
package bcd_pkg;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    // Codes 10-15 are not BCD; they render as a dash so a broken counter is visible.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// Purely combinational BCD to active-high 7-segment decoder.
module bcd_seg_decoder
    import bcd_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    assign seg_o = bcd_to_seg(bcd_i);

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 7-segment scanner for a chain of BCD digits. A shadow copy of
// the digits is taken once per frame so a digit never changes while lit; each
// digit slot starts with one dark guard cycle to avoid ghosting between digits.
module bcd_display_scan
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE       = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_start
);

    localparam int PCNT_W = $clog2(PRESCALE);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PCNT_W-1:0]     PCNT_LAST = PCNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_DARK  = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_DARK   = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] DIG_DARK  = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              load_pending_q, load_pending_d;
    logic              tick, load;

    logic [NUM_DIGITS-1:0][3:0] dig_sh_q;
    logic [NUM_DIGITS-1:0]      dp_sh_q;
    logic                       blz_sh_q;

    logic [NUM_DIGITS-1:0] blank_vec;
    logic                  all_zero;
    logic [6:0]            dec_seg;
    logic                  lit;
    logic [6:0]            seg_act;
    logic                  dp_act;
    logic [NUM_DIGITS-1:0] dig_act;

    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  frame_start_q;

    // Prescaler, slot index and snapshot-load control.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        pcnt_d         = pcnt_q;
        idx_d          = idx_q;
        load_pending_d = load_pending_q;
        tick           = en && (pcnt_q == PCNT_LAST);
        load           = en && (load_pending_q || (tick && idx_q == IDX_LAST));
        if (en) begin
            pcnt_d = tick ? '0 : pcnt_q + PCNT_W'(1);
        end
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        if (load) begin
            load_pending_d = 1'b0;
        end
    end

    // Leading-zero mask: walk down from the most significant digit while all are zero.
    always_comb begin
        // NOTE: blocking assignments here are intentional; all_zero accumulates down the loop within one evaluation.
        all_zero  = 1'b1;
        blank_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero     = all_zero && (dig_sh_q[i] == 4'd0);
            blank_vec[i] = (i != 0) && blz_sh_q && all_zero;
        end
    end

    bcd_seg_decoder u_dec (
        .bcd_i (dig_sh_q[idx_q]),
        .seg_o (dec_seg)
    );

    // Glyph selection, guard-cycle darkening and output polarity.
    always_comb begin
        lit     = en && (pcnt_q != '0);
        seg_act = SEG_OFF;
        dp_act  = 1'b0;
        dig_act = '0;
        if (lit) begin
            seg_act        = blank_vec[idx_q] ? SEG_OFF : dec_seg;
            dp_act         = dp_sh_q[idx_q];
            dig_act[idx_q] = 1'b1;
        end
        seg_d = seg_act ^ {7{SEG_ACTIVE_LOW}};
        dp_d  = dp_act ^ SEG_ACTIVE_LOW;
        dig_d = dig_act ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
    end

    // State, shadow snapshot and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            pcnt_q         <= '0;
            idx_q          <= '0;
            load_pending_q <= 1'b1;
            // NOTE: the shadow bank is reset explicitly; it is tiny and a known value keeps the first frame defined.
            dig_sh_q       <= '0;
            dp_sh_q        <= '0;
            blz_sh_q       <= 1'b0;
            seg_q          <= SEG_DARK;
            dp_q           <= DP_DARK;
            dig_q          <= DIG_DARK;
            frame_start_q  <= 1'b0;
        end else begin
            pcnt_q         <= pcnt_d;
            idx_q          <= idx_d;
            load_pending_q <= load_pending_d;
            if (load) begin
                dig_sh_q <= digits_in;
                dp_sh_q  <= dp_in;
                blz_sh_q <= blank_lz;
            end
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            dig_q         <= dig_d;
            frame_start_q <= load;
        end
    end

    assign seg_out     = seg_q;
    assign dp_out      = dp_q;
    assign dig_sel     = dig_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan (4 digits, prescale 4, active-low).
// The reference model tracks the count of enabled cycles since reset and derives
// slot position, frame boundaries and glyphs from it arithmetically.
module tb_bcd_display_scan;

    localparam int N = 4;
    localparam int P = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [15:0]   digits_in;
    logic [3:0]    dp_in;
    logic          blank_lz;
    logic [6:0]    seg_out;
    logic          dp_out;
    logic [3:0]    dig_sel;
    logic          frame_start;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int    ecount;
    bit    pend;
    int    sh_dig[N];
    bit    sh_dp[N];
    bit    sh_blz;
    bit    valid = 1'b0;
    string phase = "init";

    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_dig;
    logic       e_fs;

    always #5 clk = ~clk;

    bcd_display_scan #(
        .NUM_DIGITS     (N),
        .PRESCALE       (P),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_lz    (blank_lz),
        .seg_out     (seg_out),
        .dp_out      (dp_out),
        .dig_sel     (dig_sel),
        .frame_start (frame_start)
    );

    // Active-high glyphs {g,f,e,d,c,b,a}; anything above 9 is a dash.
    function automatic logic [6:0] glyph(input int code);
        case (code)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: predict outputs from model state and inputs, step the model,
    // then compare after the edge.
    task automatic cycle();
        bit         do_chk;
        bit         allz;
        bit         blank;
        int         slot;
        logic [6:0] act;
        logic [3:0] oh;
        do_chk = valid || !rst_n;
        e_seg  = 7'h7F;
        e_dp   = 1'b1;
        e_dig  = 4'hF;
        e_fs   = 1'b0;
        if (!rst_n) begin
            ecount = 0;
            pend   = 1'b1;
            for (int i = 0; i < N; i++) begin
                sh_dig[i] = 0;
                sh_dp[i]  = 1'b0;
            end
            sh_blz = 1'b0;
            valid  = 1'b1;
        end else if (en) begin
            if (ecount % P != 0) begin
                slot = (ecount / P) % N;
                allz = 1'b1;
                for (int j = slot; j < N; j++) begin
                    if (sh_dig[j] != 0) allz = 1'b0;
                end
                blank = (slot > 0) && sh_blz && allz;
                act   = blank ? 7'b0000000 : glyph(sh_dig[slot]);
                oh    = 4'b0001 << slot;
                e_seg = ~act;
                e_dp  = ~sh_dp[slot];
                e_dig = ~oh;
            end
            if (pend || (ecount % (P * N) == P * N - 1)) begin
                for (int i = 0; i < N; i++) begin
                    sh_dig[i] = int'(digits_in[4*i +: 4]);
                    sh_dp[i]  = dp_in[i];
                end
                sh_blz = blank_lz;
                pend   = 1'b0;
                e_fs   = 1'b1;
            end
            ecount++;
        end
        @(posedge clk);
        #1;
        if (do_chk) begin
            check({phase, ".seg"}, 32'(seg_out), 32'(e_seg));
            check({phase, ".dp"}, 32'(dp_out), 32'(e_dp));
            check({phase, ".dig"}, 32'(dig_sel), 32'(e_dig));
            check({phase, ".fs"}, 32'(frame_start), 32'(e_fs));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_dig(input logic [3:0] target, input string tag);
        int n;
        n = 0;
        while (dig_sel !== target && n < 64) begin
            cycle();
            n++;
        end
        check({tag, ".reach"}, 32'(dig_sel), 32'(target));
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < 64) begin
            cycle();
            n++;
        end
        check({tag, ".frame"}, 32'(frame_start), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        digits_in = 16'h1234;
        dp_in     = 4'b0000;
        blank_lz  = 1'b0;

        phase = "reset";
        run(2);
        check("reset.seg_const", 32'(seg_out), 32'h7F);
        check("reset.dig_const", 32'(dig_sel), 32'hF);
        rst_n = 1'b1;

        phase = "d1234";
        run(2 * P * N);
        wait_dig(4'b1110, "d1234");
        check("d1234.digit0_four", 32'(seg_out), 32'b0011001);

        phase = "lz7";
        digits_in = 16'h0007;
        blank_lz  = 1'b1;
        run(2 * P * N);
        wait_dig(4'b1110, "lz7");
        check("lz7.digit0", 32'(seg_out), 32'b1111000);
        wait_dig(4'b1101, "lz7");
        check("lz7.digit1_blank", 32'(seg_out), 32'h7F);

        phase = "lz0";
        digits_in = 16'h0000;
        run(2 * P * N);
        wait_dig(4'b1110, "lz0");
        check("lz0.digit0_zero", 32'(seg_out), 32'b1000000);

        phase = "tear";
        digits_in = 16'h1111;
        blank_lz  = 1'b0;
        run(2 * P * N);
        wait_dig(4'b1101, "tear");
        digits_in = 16'h2222;
        wait_dig(4'b1011, "tear");
        check("tear.digit2_old", 32'(seg_out), 32'b1111001);
        wait_dig(4'b0111, "tear");
        check("tear.digit3_old", 32'(seg_out), 32'b1111001);
        wait_frame("tear");
        wait_dig(4'b1110, "tear");
        check("tear.digit0_new", 32'(seg_out), 32'b0100100);

        phase = "dash";
        digits_in = 16'h0A00;
        blank_lz  = 1'b1;
        dp_in     = 4'b1000;
        run(2 * P * N);
        wait_dig(4'b0111, "dash");
        check("dash.digit3_dark", 32'(seg_out), 32'h7F);
        check("dash.digit3_dp", 32'(dp_out), 32'd0);
        wait_dig(4'b1011, "dash");
        check("dash.digit2_dash", 32'(seg_out), 32'b0111111);

        phase = "enlow";
        dp_in = 4'b0000;
        digits_in = 16'h5678;
        wait_dig(4'b1101, "enlow");
        cycle();
        en = 1'b0;
        run(5);
        check("enlow.dark", 32'(dig_sel), 32'hF);
        en = 1'b1;
        run(3 * P * N);

        phase = "midrst";
        wait_dig(4'b1011, "midrst");
        rst_n = 1'b0;
        cycle();
        check("midrst.seg", 32'(seg_out), 32'h7F);
        check("midrst.dig", 32'(dig_sel), 32'hF);
        rst_n = 1'b1;
        run(2 * P * N);

        phase = "rand";
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < N; i++) begin
                    digits_in[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                end
                dp_in    = 4'($urandom_range(0, 15));
                blank_lz = 1'($urandom_range(0, 1));
            end
            en    = ($urandom_range(0, 9) != 0);
            rst_n = ($urandom_range(0, 199) != 0);
            cycle();
        end
        rst_n = 1'b1;
        en    = 1'b1;
        run(P * N);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
